adat_resync_scheduler: RTL and testbench
========================================

ADAT_RESYNC_SCHEDULER -- requirements
Module: adat_resync_scheduler

Interface
REQ-001 Parameter NUM_CH, default 4, number of ADAT receive channels served (2..8).
REQ-002 Parameter SETTLE_CYCLES, default 4096, clk_x4_i cycles a channel must stay locked before resync is requested.
REQ-003 Parameter TIMEOUT_CYCLES, default 65536, cycles to wait for i2s_running after a request.
REQ-004 Parameter MAX_RETRY, default 3, request attempts per service before fault.
REQ-005 clk_x4_i  input  1  sole clock, rising edge.
REQ-006 reset_ni  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-007 adat_locked_i  input  NUM_CH  per-channel lock status, synchronous to clk_x4_i.
REQ-008 i2s_running_i  input  NUM_CH  per-channel I2S running status.
REQ-009 force_resync_i  input  NUM_CH  per-channel host resync request, single-cycle pulses.
REQ-010 resync_req_o  output  NUM_CH  one-hot single-cycle resync pulse to the selected channel.
REQ-011 active_ch_o  output  clog2(NUM_CH)  channel being serviced; 0 when idle.
REQ-012 busy_o  output  1  high in any state other than IDLE.
REQ-013 ch_ready_o  output  NUM_CH  channel resynced and running.
REQ-014 ch_fault_o  output  NUM_CH  channel exhausted MAX_RETRY attempts.

Function
REQ-015 Pending flag per channel SHALL be set on a registered rising edge of adat_locked_i[n] or on force_resync_i[n]; both in the same cycle set one flag.
REQ-016 Pending[n] SHALL clear when channel n is selected, or when adat_locked_i[n] is low.
REQ-017 States SHALL be IDLE, SETTLE, REQ, WAIT_RUN.
REQ-018 IDLE: if any pending, select by round-robin starting at the channel after the last served, register it on active_ch_o, load settle counter, enter SETTLE next cycle.
REQ-019 SETTLE: counter decrements each cycle; on reaching zero enter REQ; resync_req_o SHALL assert exactly SETTLE_CYCLES+1 cycles after leaving IDLE.
REQ-020 REQ: assert resync_req_o[active] for one cycle, clear retry-independent timer, enter WAIT_RUN.
REQ-021 WAIT_RUN: success when i2s_running_i[active] is high in any cycle at least 2 cycles after the request pulse; set ch_ready_o[active], clear ch_fault_o[active], go IDLE.
REQ-022 WAIT_RUN timeout after TIMEOUT_CYCLES: increment retry count; if count < MAX_RETRY return to REQ, else set ch_fault_o[active], clear ch_ready_o[active], go IDLE.
REQ-023 Loss of adat_locked_i[active] in SETTLE or WAIT_RUN SHALL abort to IDLE next cycle without request or fault update.
REQ-024 ch_ready_o[n] SHALL clear the cycle after adat_locked_i[n] falls or when channel n is next selected.
REQ-025 force_resync_i on the active channel SHALL set its pending flag; it is serviced after the current service ends.
REQ-026 At most one bit of resync_req_o SHALL be high in any cycle; never high outside REQ.
REQ-027 Counters SHALL be sized to hold their parameter value without wrap; retry count resets on each new selection.

Reset
REQ-028 reset_ni low SHALL asynchronously force IDLE, all pending/ready/fault flags 0, resync_req_o 0, busy_o 0, active_ch_o 0, round-robin pointer to channel 0, edge-detect registers 0.
REQ-029 Reset assertion mid-request SHALL drop resync_req_o within the same cycle; after release, channels already locked are treated as new rising edges.

Verification
REQ-030 Ch1 lock rises, SETTLE_CYCLES=16, running rises 5 cycles after req -> resync_req_o=0010 one cycle, 17 cycles after leaving IDLE; ch_ready_o=0010.
REQ-031 Ch0 and ch2 lock same cycle -> ch0 serviced first, then ch2; never two req bits high.
REQ-032 Running never rises, TIMEOUT_CYCLES=32, MAX_RETRY=3 -> three req pulses 33 cycles apart, then ch_fault_o set, busy_o low.
REQ-033 Lock drops during SETTLE -> no req pulse, IDLE next cycle, no fault.
REQ-034 Force on ready ch3 -> ch_ready_o[3] clears at selection, new req pulse, ready again after running.
REQ-035 reset_ni low during WAIT_RUN -> all outputs 0 immediately; locked channels re-serviced after release.

Source files
------------

// File: rtl/adat_resync_scheduler.sv
// ============================================================================
// adat_resync_scheduler: round-robin ADAT lock settle / I2S resync sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module adat_resync_scheduler #(
    parameter int NUM_CH         = 4,
    parameter int SETTLE_CYCLES  = 4096,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRY      = 3
) (
    input  logic                      clk_x4_i,
    input  logic                      reset_ni,
    input  logic [NUM_CH-1:0]         adat_locked_i,
    input  logic [NUM_CH-1:0]         i2s_running_i,
    input  logic [NUM_CH-1:0]         force_resync_i,
    output logic [NUM_CH-1:0]         resync_req_o,
    output logic [$clog2(NUM_CH)-1:0] active_ch_o,
    output logic                      busy_o,
    output logic [NUM_CH-1:0]         ch_ready_o,
    output logic [NUM_CH-1:0]         ch_fault_o
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RTY_W = $clog2(MAX_RETRY + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETTLE   = 2'd1,
        REQ      = 2'd2,
        WAIT_RUN = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic [NUM_CH-1:0]   lock_q, pending, ready, fault;
    logic [NUM_CH-1:0]   sel_mask, ready_nxt, fault_nxt;
    logic [CH_W-1:0]     active, rr_ptr, pick;
    logic [SET_W-1:0]    settle_cnt;
    logic [TMO_W-1:0]    timer;
    logic [RTY_W-1:0]    retry;
    logic                select, succeed, give_up, retry_again;
    logic                act_locked, act_running, timeout, retry_last;

    assign act_locked  = adat_locked_i[active];
    assign act_running = i2s_running_i[active];
    assign timeout     = (timer == TMO_W'(TIMEOUT_CYCLES - 1));
    assign retry_last  = (int'(retry) + 1) >= MAX_RETRY;

    // Round-robin search from rr_ptr; walking backwards lets the nearest pending win.
    always_comb begin
        pick = rr_ptr;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            int j;
            j = int'(rr_ptr) + i;
            if (j >= NUM_CH) j = j - NUM_CH;
            if (pending[j]) pick = CH_W'(j);
        end
    end

    always_comb begin
        state_nxt   = state;
        select      = 1'b0;
        succeed     = 1'b0;
        give_up     = 1'b0;
        retry_again = 1'b0;
        sel_mask    = '0;
        case (state)
            IDLE: begin
                if (|pending) begin
                    select         = 1'b1;
                    sel_mask[pick] = 1'b1;
                    state_nxt      = SETTLE;
                end
            end
            SETTLE: begin
                if (!act_locked)         state_nxt = IDLE;
                else if (settle_cnt == '0) state_nxt = REQ;
            end
            REQ: state_nxt = WAIT_RUN;
            WAIT_RUN: begin
                // timer != 0 means at least two cycles have passed since the pulse
                if (!act_locked) begin
                    state_nxt = IDLE;
                end else if (act_running && timer != '0) begin
                    succeed   = 1'b1;
                    state_nxt = IDLE;
                end else if (timeout) begin
                    if (retry_last) begin
                        give_up   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        retry_again = 1'b1;
                        state_nxt   = REQ;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready_nxt = ready & adat_locked_i & ~sel_mask;
        fault_nxt = fault;
        if (succeed) begin
            ready_nxt[active] = 1'b1;
            fault_nxt[active] = 1'b0;
        end
        if (give_up) begin
            ready_nxt[active] = 1'b0;
            fault_nxt[active] = 1'b1;
        end
    end

    always_comb begin
        resync_req_o = '0;
        if (state == REQ) resync_req_o[active] = 1'b1;
    end

    always_ff @(posedge clk_x4_i or negedge reset_ni) begin
        if (!reset_ni) state <= IDLE;
        else           state <= state_nxt;
    end

    always_ff @(posedge clk_x4_i or negedge reset_ni) begin
        if (!reset_ni) begin
            lock_q     <= '0;
            pending    <= '0;
            ready      <= '0;
            fault      <= '0;
            active     <= '0;
            rr_ptr     <= '0;
            settle_cnt <= '0;
            timer      <= '0;
            retry      <= '0;
        end else begin
            lock_q  <= adat_locked_i;
            pending <= adat_locked_i & ((pending & ~sel_mask) |
                                        (adat_locked_i & ~lock_q) | force_resync_i);
            ready   <= ready_nxt;
            fault   <= fault_nxt;
            if (select) begin
                active     <= pick;
                rr_ptr     <= (pick == CH_W'(NUM_CH - 1)) ? '0 : pick + 1'b1;
                settle_cnt <= SET_W'(SETTLE_CYCLES);
                retry      <= '0;
            end else if (state != IDLE && state_nxt == IDLE) begin
                active <= '0;
            end
            if (state == SETTLE && settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
            if (state == REQ)                        timer <= '0;
            else if (state == WAIT_RUN && !timeout)  timer <= timer + 1'b1;
            if (retry_again) retry <= retry + 1'b1;
        end
    end

    assign active_ch_o = active;
    assign busy_o      = (state != IDLE);
    assign ch_ready_o  = ready;
    assign ch_fault_o  = fault;

endmodule

`default_nettype wire

// File: tb/tb_adat_resync_scheduler.sv
// ============================================================================
// tb_adat_resync_scheduler: vector table plus scoreboarded resync pulse checks
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_adat_resync_scheduler;

    localparam int SETTLE  = 16;
    localparam int TIMEOUT = 32;
    localparam int RETRIES = 3;

    logic       clk = 1'b0;
    logic       reset_ni = 1'b0;
    logic [3:0] locks = '0, running = '0, frc = '0;
    logic [3:0] req, ready, fault;
    logic [1:0] active;
    logic       busy;

    adat_resync_scheduler #(
        .NUM_CH(4), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT), .MAX_RETRY(RETRIES)
    ) dut (
        .clk_x4_i(clk), .reset_ni(reset_ni), .adat_locked_i(locks),
        .i2s_running_i(running), .force_resync_i(frc), .resync_req_o(req),
        .active_ch_o(active), .busy_o(busy), .ch_ready_o(ready), .ch_fault_o(fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       force_it;
        int         ch;
        int         run_delay;
        int         pulses;
        logic [3:0] exp_ready;
        logic [3:0] exp_fault;
    } vec_t;

    vec_t       vecs[6];
    logic [3:0] exp_q[$];
    int         checks = 0, failures = 0;
    int         cyc = 0, t_start = 0, t_last = 0, pulse_cnt = 0;
    int         rd[4], cd[4];
    logic       prev_busy = 1'b0, first_pulse = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: sample at the falling edge, score resync pulses, model I2S start-up.
    task automatic tick();
        logic [3:0] e;
        int         ei;
        @(negedge clk);
        cyc++;
        if (!reset_ni) begin
            prev_busy = 1'b0;
            return;
        end
        for (int c = 0; c < 4; c++) begin
            if (cd[c] > 0) begin
                cd[c]--;
                if (cd[c] == 0) begin
                    running[c] = 1'b1;
                    cd[c] = -1;
                end
            end
        end
        if (busy && !prev_busy) begin
            t_start     = cyc;
            first_pulse = 1'b1;
        end
        prev_busy = busy;
        if (req != '0) begin
            check("req_onehot", 32'($onehot(req)), 32'd1);
            if (exp_q.size() == 0) begin
                check("req_unexpected", 32'(req), 32'd0);
            end else begin
                e  = exp_q.pop_front();
                ei = 0;
                for (int c = 0; c < 4; c++) if (e[c]) ei = c;
                check("req_ch", 32'(req), 32'(e));
                check("req_active_ch", 32'(active), 32'(ei));
            end
            if (first_pulse) check("settle_delay", 32'(cyc - t_start), 32'(SETTLE + 1));
            else             check("retry_gap", 32'(cyc - t_last), 32'(TIMEOUT + 1));
            first_pulse = 1'b0;
            t_last      = cyc;
            pulse_cnt++;
            for (int c = 0; c < 4; c++) begin
                if (req[c]) begin
                    running[c] = 1'b0;
                    cd[c]      = rd[c];
                end
            end
        end
    endtask

    task automatic wait_busy(input logic lvl, input int lim, input string name);
        int n = 0;
        while (busy !== lvl && n < lim) begin
            tick();
            n++;
        end
        check(name, 32'(busy), 32'(lvl));
    endtask

    task automatic wait_done(input logic [3:0] rdy, input int lim, input string name);
        int n = 0;
        while (!(ready === rdy && busy === 1'b0) && n < lim) begin
            tick();
            n++;
        end
        check(name, 32'(ready), 32'(rdy));
    endtask

    initial begin
        int p0;
        int n;
        vecs[0] = '{1'b0, 1,  5, 1, 4'b0111, 4'b0000};
        vecs[1] = '{1'b0, 3, -1, 3, 4'b0111, 4'b1000};
        vecs[2] = '{1'b1, 3,  1, 1, 4'b1111, 4'b0000};
        vecs[3] = '{1'b1, 0, 31, 1, 4'b1111, 4'b0000};
        vecs[4] = '{1'b1, 2, -1, 3, 4'b1011, 4'b0100};
        vecs[5] = '{1'b1, 2,  3, 1, 4'b1111, 4'b0000};
        for (int c = 0; c < 4; c++) begin
            rd[c] = 2;
            cd[c] = -1;
        end

        repeat (2) tick();
        check("rst_req", 32'(req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_active", 32'(active), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        reset_ni = 1'b1;
        tick();

        // Two channels lock together: lowest channel first after reset.
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0100);
        locks = 4'b0101;
        wait_done(4'b0101, 200, "dual_lock_ready");
        check("dual_lock_fault", 32'(fault), 32'd0);
        check("dual_lock_sb_empty", 32'(exp_q.size()), 32'd0);

        for (int v = 0; v < 6; v++) begin
            rd[vecs[v].ch] = vecs[v].run_delay;
            for (int k = 0; k < vecs[v].pulses; k++) exp_q.push_back(4'b0001 << vecs[v].ch);
            p0 = pulse_cnt;
            if (vecs[v].force_it) frc[vecs[v].ch] = 1'b1;
            else                  locks[vecs[v].ch] = 1'b1;
            tick();
            frc = '0;
            wait_busy(1'b1, 10, "vec_busy_rise");
            if (vecs[v].force_it) check("vec_ready_clr_at_sel", 32'(ready[vecs[v].ch]), 32'd0);
            wait_busy(1'b0, 300, "vec_busy_fall");
            tick();
            check("vec_pulses", 32'(pulse_cnt - p0), 32'(vecs[v].pulses));
            check("vec_ready", 32'(ready), 32'(vecs[v].exp_ready));
            check("vec_fault", 32'(fault), 32'(vecs[v].exp_fault));
            check("vec_sb_empty", 32'(exp_q.size()), 32'd0);
        end

        // Lock lost during SETTLE: abort with no request and no fault.
        p0 = pulse_cnt;
        frc[1] = 1'b1;
        tick();
        frc = '0;
        wait_busy(1'b1, 10, "abort_busy_rise");
        repeat (5) tick();
        locks[1] = 1'b0;
        tick();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_active", 32'(active), 32'd0);
        repeat (40) tick();
        check("abort_no_pulse", 32'(pulse_cnt - p0), 32'd0);
        check("abort_fault", 32'(fault), 32'd0);
        check("abort_ready", 32'(ready), 32'b1101);

        // Reset in WAIT_RUN: outputs drop at once, locked channels serviced again.
        rd[2] = -1;
        exp_q.push_back(4'b0100);
        frc[2] = 1'b1;
        tick();
        frc = '0;
        p0 = pulse_cnt;
        n  = 0;
        while (pulse_cnt == p0 && n < 40) begin
            tick();
            n++;
        end
        check("rst_run_pulse_seen", 32'(pulse_cnt - p0), 32'd1);
        repeat (3) tick();
        #2 reset_ni = 1'b0;
        #1;
        check("async_rst_req", 32'(req), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_active", 32'(active), 32'd0);
        check("async_rst_ready", 32'(ready), 32'd0);
        check("async_rst_fault", 32'(fault), 32'd0);
        rd[0] = 2;
        rd[2] = 2;
        rd[3] = 2;
        repeat (2) tick();
        reset_ni = 1'b1;
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000);
        wait_done(4'b1101, 300, "reservice_ready");
        check("reservice_fault", 32'(fault), 32'd0);
        check("reservice_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
